// File: rtl/spi_three_wire_read_if.sv
// Register-access side of the three-wire SPI read master: start request,
// command word, read data and completion pulse.
interface spi_three_wire_read_if #(
  parameter int CMD_BITS  = 8,
  parameter int DATA_BITS = 8
);
  logic                 GO;
  logic [CMD_BITS-1:0]  regcmd;
  logic [DATA_BITS-1:0] RDATA;
  logic                 ORDY;

  // master: the register-access controller; slave: the SPI read engine
  modport master (
    output GO,
    output regcmd,
    input  RDATA,
    input  ORDY
  );

  modport slave (
    input  GO,
    input  regcmd,
    output RDATA,
    output ORDY
  );
endinterface

// File: rtl/spi_three_wire_read.sv
// Three-wire SPI read master: shifts out a command on shared SDAT, turns the line around,
// shifts in the register data. Optional macro SPI_FORCE_RBIT_EN forces the command MSB to 1.
module spi_three_wire_read #(
  parameter int CLK_DIV   = 2,
  parameter int CMD_BITS  = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  spi_three_wire_read_if.slave  ctl,
  output logic                  SPC,
  output logic                  SCEN,
  inout  wire                   SDAT
);

  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAX_BITS = (CMD_BITS > DATA_BITS) ? CMD_BITS : DATA_BITS;
  localparam int BIT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] CMD_LAST  = BIT_W'(CMD_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    CMD,
    DATA,
    STOP
  } state_t;

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [CMD_BITS-1:0]  tx_sr;
  logic [DATA_BITS-1:0] rx_sr;
  logic [DATA_BITS-1:0] rdata;
  logic                 ordy;
  logic                 spc;
  logic                 scen;
  logic                 sdat_oe;
  logic                 half_end;

  function automatic logic [CMD_BITS-1:0] tx_word(input logic [CMD_BITS-1:0] c);
    logic [CMD_BITS-1:0] w;
    w = c;
`ifdef SPI_FORCE_RBIT_EN
    w[CMD_BITS-1] = 1'b1;
`endif
    return w;
  endfunction

  assign half_end  = (div_cnt == DIV_LAST);

  // The wire always carries the MSB of the command shifter while the master owns it.
  assign SDAT      = sdat_oe ? tx_sr[CMD_BITS-1] : 1'bz;
  assign SPC       = spc;
  assign SCEN      = scen;
  assign ctl.RDATA = rdata;
  assign ctl.ORDY  = ordy;

  // Within CMD and DATA the registered SPC level doubles as the half-period marker:
  // spc==0 means the low half of the current bit, spc==1 the high half.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rdata   <= '0;
      ordy    <= 1'b0;
      spc     <= 1'b1;
      scen    <= 1'b1;
      sdat_oe <= 1'b0;
    end else begin
      ordy <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          if (ctl.GO) begin
            tx_sr <= tx_word(ctl.regcmd);
            scen  <= 1'b0;
            state <= START;
          end
        end

        START: begin
          if (half_end) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            spc     <= 1'b0;
            sdat_oe <= 1'b1;
            state   <= CMD;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        CMD: begin
          if (half_end) begin
            div_cnt <= '0;
            if (!spc) begin
              spc <= 1'b1;
            end else if (bit_cnt == CMD_LAST) begin
              // Turnaround: release SDAT on the same falling edge that opens DATA.
              spc     <= 1'b0;
              sdat_oe <= 1'b0;
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              spc     <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
              tx_sr   <= tx_sr << 1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        DATA: begin
          if (half_end) begin
            div_cnt <= '0;
            if (!spc) begin
              spc   <= 1'b1;
              rx_sr <= (rx_sr << 1) | DATA_BITS'(SDAT);
            end else if (bit_cnt == DATA_LAST) begin
              // SPC stays high into STOP; no trailing falling edge.
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              spc     <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        STOP: begin
          if (half_end) begin
            div_cnt <= '0;
            scen    <= 1'b1;
            rdata   <= rx_sr;
            ordy    <= 1'b1;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          div_cnt <= '0;
          bit_cnt <= '0;
          spc     <= 1'b1;
          scen    <= 1'b1;
          sdat_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
